// File: rtl/rat_pkg.sv
// rat_pkg: shared state encoding, default width and GCD cycle bound for the rational multiplier
package rat_pkg;

    localparam int RAT_WIDTH = 32;

    typedef enum logic [2:0] {IDLE, MUL, GCD, DIVN, DIVD, DONE} rat_mul_state_t;

    function automatic int gcd_max_cycles(input int w);
        return 4 * w + 2;
    endfunction

endpackage

// File: rtl/rat_seq_div.sv
// rat_seq_div: restoring unsigned divider, one quotient bit per cycle
module rat_seq_div #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quot
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    // one restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        w_sh      = {r_rem, r_q[WIDTH-1]};
        w_diff    = w_sh - {1'b0, r_d};
        w_ge      = w_sh >= {1'b0, r_d};
        w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
        w_q_nxt   = {r_q[WIDTH-2:0], w_ge};
    end

    // start reloads even on the finishing cycle so back-to-back divides chain without a gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_q    <= i_dividend;
            r_d    <= i_divisor;
            r_cnt  <= CW'(WIDTH);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem  <= w_rem_nxt;
            r_q    <= w_q_nxt;
            r_cnt  <= r_cnt - CW'(1);
            r_busy <= r_cnt != CW'(1);
        end
    end

    // done marks the cycle whose edge completes the last step; quotient is the value being written
    assign o_busy = r_busy;
    assign o_done = r_busy && r_cnt == CW'(1);
    assign o_quot = w_q_nxt;

endmodule

// File: rtl/rat_mul_seq.sv
// rat_mul_seq: sequential rational multiplier with optional lowest-terms reduction
module rat_mul_seq
    import rat_pkg::*;
#(
    parameter int WIDTH = RAT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] l_num,
    input  logic [WIDTH-1:0] l_den,
    input  logic [WIDTH-1:0] r_num,
    input  logic [WIDTH-1:0] r_den,
    input  logic             reduce,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_num,
    output logic [WIDTH-1:0] s_den,
    output logic             ovf,
    output logic             div_zero
);

    localparam int W2 = 2 * WIDTH;
    localparam int KW = $clog2(W2) + 1;

    rat_mul_state_t r_state, w_next;
    logic [WIDTH-1:0] r_ln, r_ld, r_rn, r_rd;
    logic             r_red;
    logic [W2-1:0]    r_pn, r_pd, r_a, r_b, r_g, r_qn;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_s_num, r_s_den;
    logic             r_ovf, r_dz;
    logic [W2-1:0]    w_pn, w_pd, w_g, w_a_nxt, w_b_nxt;
    logic [KW-1:0]    w_k_nxt;
    logic             w_dz, w_gcd_done;
    logic             w_div_start, w_div_busy, w_div_done, w_div_fin;
    logic [W2-1:0]    w_div_n, w_div_d, w_quot;

    assign w_pn       = W2'(r_ln) * W2'(r_rn);
    assign w_pd       = W2'(r_ld) * W2'(r_rd);
    assign w_dz       = r_ld == '0 || r_rd == '0;
    assign w_gcd_done = r_a == '0;
    assign w_g        = r_b << r_k;
    assign w_div_fin  = w_div_busy && w_div_done;

    // one Stein step: strip common twos into k, strip lone twos, otherwise halve the odd difference
    always_comb begin
        w_a_nxt = r_a;
        w_b_nxt = r_b;
        w_k_nxt = r_k;
        if (!r_a[0] && !r_b[0]) begin
            w_a_nxt = r_a >> 1;
            w_b_nxt = r_b >> 1;
            w_k_nxt = r_k + KW'(1);
        end else if (!r_a[0]) begin
            w_a_nxt = r_a >> 1;
        end else if (!r_b[0]) begin
            w_b_nxt = r_b >> 1;
        end else if (r_a >= r_b) begin
            w_a_nxt = (r_a - r_b) >> 1;
        end else begin
            w_b_nxt = (r_b - r_a) >> 1;
        end
    end

    // the single divider is launched for pn/g when GCD ends and for pd/g the cycle DIVN finishes
    always_comb begin
        w_div_start = (r_state == GCD && w_gcd_done) || (r_state == DIVN && w_div_fin);
        w_div_n     = r_state == GCD ? r_pn : r_pd;
        w_div_d     = r_state == GCD ? w_g : r_g;
    end

    rat_seq_div #(.WIDTH(W2)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_dividend (w_div_n),
        .i_divisor  (w_div_d),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quot     (w_quot)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state and handshake outputs
    always_comb begin
        w_next    = r_state;
        in_ready  = r_state == IDLE;
        out_valid = r_state == DONE;
        case (r_state)
            IDLE:    w_next = in_valid ? MUL : IDLE;
            MUL:     w_next = (w_dz || !r_red) ? DONE : GCD;
            GCD:     w_next = w_gcd_done ? DIVN : GCD;
            DIVN:    w_next = w_div_fin ? DIVD : DIVN;
            DIVD:    w_next = w_div_fin ? DONE : DIVD;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // datapath: operand capture, products, GCD iteration and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ln    <= '0;
            r_ld    <= '0;
            r_rn    <= '0;
            r_rd    <= '0;
            r_red   <= 1'b0;
            r_pn    <= '0;
            r_pd    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_g     <= '0;
            r_k     <= '0;
            r_qn    <= '0;
            r_s_num <= '0;
            r_s_den <= '0;
            r_ovf   <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_ln  <= l_num;
                    r_ld  <= l_den;
                    r_rn  <= r_num;
                    r_rd  <= r_den;
                    r_red <= reduce;
                end
                MUL: begin
                    r_pn <= w_pn;
                    r_pd <= w_pd;
                    r_a  <= w_pn;
                    r_b  <= w_pd;
                    r_k  <= '0;
                    if (w_dz) begin
                        r_s_num <= '0;
                        r_s_den <= '0;
                        r_ovf   <= 1'b0;
                        r_dz    <= 1'b1;
                    end else if (!r_red) begin
                        r_s_num <= w_pn[WIDTH-1:0];
                        r_s_den <= w_pd[WIDTH-1:0];
                        r_ovf   <= |w_pn[W2-1:WIDTH] || |w_pd[W2-1:WIDTH];
                        r_dz    <= 1'b0;
                    end
                end
                GCD: if (w_gcd_done) begin
                    r_g <= w_g;
                end else begin
                    r_a <= w_a_nxt;
                    r_b <= w_b_nxt;
                    r_k <= w_k_nxt;
                end
                DIVN: if (w_div_fin) r_qn <= w_quot;
                DIVD: if (w_div_fin) begin
                    r_s_num <= r_qn[WIDTH-1:0];
                    r_s_den <= w_quot[WIDTH-1:0];
                    r_ovf   <= |r_qn[W2-1:WIDTH] || |w_quot[W2-1:WIDTH];
                    r_dz    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign s_num    = r_s_num;
    assign s_den    = r_s_den;
    assign ovf      = r_ovf;
    assign div_zero = r_dz;

endmodule

// File: doc/rat_mul_seq.md
Name: rat_mul_seq

Overview:
- Parametrised successor to the combinational rational multiplier `mul`.
- Multiplies two unsigned rationals (l_num/l_den)*(r_num/r_den) with valid/ready handshakes on input and output.
- Adds a per-transaction reduce mode: GCD normalisation of the full-precision product, plus zero-denominator and overflow flags.
- Sits in the rat arithmetic datapath in front of consumers that need lowest-terms results.

Parameters:
- WIDTH, 32: bit width of every numerator/denominator port. Internal products are 2*WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept operands
- l_num  in  WIDTH  left numerator, unsigned
- l_den  in  WIDTH  left denominator, unsigned
- r_num  in  WIDTH  right numerator, unsigned
- r_den  in  WIDTH  right denominator, unsigned
- reduce  in  1  1 = return the result in lowest terms; sampled with operands
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s_num  out  WIDTH  result numerator, low WIDTH bits
- s_den  out  WIDTH  result denominator, low WIDTH bits
- ovf  out  1  final num or den did not fit in WIDTH
- div_zero  out  1  an input denominator was 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, s_num=0, s_den=0, ovf=0, div_zero=0.
  - Any in-flight transaction is discarded.
- One transaction in flight at a time. in_ready=1 only in IDLE.
- Accept: in_valid&&in_ready at edge T. Operands and reduce are latched; later changes on the input pins are ignored.
- States: IDLE -> MUL -> (DONE | GCD -> DIVN -> DIVD -> DONE) -> IDLE.
- MUL (1 cycle, edge T+1):
  - pn = l_num*r_num and pd = l_den*r_den, both 2*WIDTH bits.
  - If l_den==0 or r_den==0: div_zero=1, s_num=0, s_den=0, ovf=0, go to DONE. Reduction is skipped.
  - Else if reduce==0: go to DONE.
- reduce==0 latency: out_valid asserted in the cycle after edge T+1, i.e. 2 cycles after the accept edge.
- GCD state:
  - Binary (Stein) GCD g of pn and pd using shift/subtract only, one step per cycle.
  - Takes at most 4*WIDTH+2 cycles.
  - gcd(0,pd)=pd, so a zero numerator yields 0/1.
- DIVN: pn/g on the shared sequential divider; exactly 2*WIDTH cycles, remainder always 0.
- DIVD: pd/g; exactly 2*WIDTH cycles.
- DONE:
  - out_valid=1.
  - s_num/s_den = low WIDTH bits of the final num/den.
  - ovf=1 iff the upper WIDTH bits of either final value are nonzero.
  - Outputs and flags hold stable while out_ready=0.
  - out_valid&&out_ready at an edge -> IDLE, out_valid=0, in_ready=1 next cycle. Data outputs keep their last value.
- Flags (ovf, div_zero) update only when entering DONE and are valid only while out_valid=1.
- in_valid while busy: ignored and not queued. The producer holds it until in_ready.
- out_ready asserted outside DONE: no effect.
- Reset mid-GCD or mid-divide: immediate abort; no out_valid pulse after release.

Decomposition:
- Package rat_pkg:
  - state enum rat_mul_state_t {IDLE, MUL, GCD, DIVN, DIVD, DONE}
  - localparam for the default WIDTH
  - function for the GCD cycle bound 4*WIDTH+2
- Sub-module rat_seq_div:
  - Restoring divider, 2*WIDTH bits, one quotient bit per cycle.
  - start/busy/done handshake, same clk/rst_n.
  - Instantiated once and reused for DIVN then DIVD.

Test Plan (WIDTH=32):
- reduce=0, (3/4)*(5/7): accept at T -> out_valid in the cycle after edge T+1, s=15/28, ovf=0, div_zero=0.
- reduce=1, (6/4)*(10/15): products 60/60 -> s=1/1. out_valid arrives within 1+(4*32+2)+2*64+1 cycles of accept.
- reduce=1, (0/5)*(7/3) -> s=0/1. Also l_den=0, (3/0)*(2/5) -> div_zero=1, s=0/0, arriving 2 cycles after accept.
- Overflow, (65536/65536)*(65536/3):
  - reduce=0 -> pn=2^32, s_num=0, ovf=1.
  - reduce=1 -> s=65536/3, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> s_num/s_den/flags stable, in_ready=0, in_valid ignored. out_ready=1 -> in_ready=1 next cycle.
- Pulse rst_n low mid-GCD -> all outputs at reset values immediately; no out_valid after release; next transaction correct.
